// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-port cache requests plus the shared memory bus
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            err;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            busy;
  logic            owner;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D cache arbiter onto one memory port with timeout abort
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            last_q, last_d, owner_q, owner_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic            gnt, done_ok, tmo, ack;
  always_comb begin
    gnt     = (bus.i_req && bus.d_req) ? ~last_q : bus.d_req;
    done_ok = state_q == BUSY && bus.mem_ready;
    tmo     = state_q == BUSY && !bus.mem_ready && cnt_q == 8'(TIMEOUT - 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && (bus.i_req || bus.d_req)) begin
      state_d = BUSY;
      cnt_d   = '0;
      last_d  = gnt;
      owner_d = gnt;
      we_d    = gnt && bus.d_we;
      addr_d  = gnt ? bus.d_addr : bus.i_addr;
      wdata_d = gnt ? bus.d_wdata : '0;
    end else if (state_q == BUSY) begin
      state_d = (done_ok || tmo) ? DONE : BUSY;
      cnt_d   = done_ok ? cnt_q : cnt_q + 8'd1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  // completion is combinational so the ack lands in the same cycle as mem_ready
  assign ack           = done_ok || tmo;
  assign bus.err       = tmo;
  assign bus.i_ack     = ack && !owner_q;
  assign bus.d_ack     = ack && owner_q;
  assign bus.i_rdata   = (done_ok && !owner_q) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (done_ok && owner_q) ? bus.mem_rdata : '0;
  assign bus.busy      = state_q != IDLE;
  assign bus.owner     = owner_q;
  assign bus.mem_req   = state_q == BUSY;
  assign bus.mem_we    = bus.mem_req && we_q;
  assign bus.mem_addr  = bus.mem_req ? addr_q : '0;
  assign bus.mem_wdata = bus.mem_req ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based ack scoreboard
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_arbiter_if #(.XLEN(32)) bus();
  mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic port; logic err; logic chk_rd; logic [31:0] rdata;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic p, input logic e, input logic c, input logic [31:0] r);
    exp_t x;
    x.port = p; x.err = e; x.chk_rd = c; x.rdata = r;
    q.push_back(x);
  endtask
  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack || bus.err) begin
        if (q.size() == 0) chk("unexpected_ack", {29'd0, bus.err, bus.d_ack, bus.i_ack}, 32'd0);
        else begin
          x = q.pop_front();
          chk("ack_port", {30'd0, bus.d_ack, bus.i_ack}, x.port ? 32'd2 : 32'd1);
          chk("ack_err", 32'(bus.err), 32'(x.err));
          if (x.chk_rd) chk("ack_rdata", x.port ? bus.d_rdata : bus.i_rdata, x.rdata);
        end
      end
    end
  endtask
  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    fork
      monitor();
      begin
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_acks", {29'd0, bus.err, bus.d_ack, bus.i_ack}, 0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        tick(); rst = 0;
        bus.mem_ready = 1;
        tick();
        @(negedge clk);
        chk("idle_ready_busy", 32'(bus.busy), 0);
        tick(); bus.mem_ready = 0;
        // single instruction read, memory answers in third BUSY cycle
        bus.i_req = 1; bus.i_addr = 32'h100;
        push(0, 0, 1, 32'hDEADBEEF);
        tick(); bus.i_req = 0; bus.i_addr = 32'h999;
        @(negedge clk);
        chk("rd_mem_req", 32'(bus.mem_req), 1);
        chk("rd_mem_addr", bus.mem_addr, 32'h100);
        chk("rd_mem_we", 32'(bus.mem_we), 0);
        chk("rd_owner", 32'(bus.owner), 0);
        tick(); tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick(); bus.mem_ready = 0;
        @(negedge clk);
        chk("rd_done_mem_req", 32'(bus.mem_req), 0);
        chk("rd_done_busy", 32'(bus.busy), 1);
        tick();
        @(negedge clk);
        chk("rd_idle_busy", 32'(bus.busy), 0);
        // round-robin with both requests held, minimum latency
        tick(); rst = 1;
        tick(); rst = 0;
        bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h10; bus.d_addr = 32'h20; bus.d_we = 0;
        for (int k = 0; k < 4; k++) begin
          push(k[0], 0, 1, 32'hA0 + 32'(k));
          tick();
          bus.mem_ready = 1; bus.mem_rdata = 32'hA0 + 32'(k);
          @(negedge clk);
          chk("rr_owner", 32'(bus.owner), 32'(k[0]));
          chk("rr_addr", bus.mem_addr, k[0] ? 32'h20 : 32'h10);
          tick(); bus.mem_ready = 0;
          @(negedge clk);
          chk("rr_done_req", 32'(bus.mem_req), 0);
          tick();
        end
        bus.i_req = 0; bus.d_req = 0;
        // data write with request inputs changing during BUSY
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h12345678;
        push(1, 0, 0, 0);
        tick();
        bus.d_req = 0; bus.d_addr = 32'h3000; bus.d_wdata = 0; bus.d_we = 0; bus.i_req = 1;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("wr_addr", bus.mem_addr, 32'h2004);
          chk("wr_wdata", bus.mem_wdata, 32'h12345678);
          chk("wr_we", 32'(bus.mem_we), 1);
          chk("wr_owner", 32'(bus.owner), 1);
          tick();
        end
        bus.i_req = 0; bus.mem_ready = 1;
        @(negedge clk);
        chk("wr_addr_ack", bus.mem_addr, 32'h2004);
        tick(); bus.mem_ready = 0;
        tick();
        // timeout abort in the fourth BUSY cycle
        bus.d_req = 1; bus.d_addr = 32'h44; bus.mem_rdata = 32'hFFFFFFFF;
        push(1, 1, 1, 0);
        tick(); bus.d_req = 0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("to_d_ack", 32'(bus.d_ack), 1);
        tick();
        @(negedge clk);
        chk("to_done_busy", 32'(bus.busy), 1);
        chk("to_done_req", 32'(bus.mem_req), 0);
        tick();
        @(negedge clk);
        chk("to_idle_busy", 32'(bus.busy), 0);
        // mem_ready coincides with the timeout cycle: normal completion
        tick();
        bus.i_req = 1; bus.i_addr = 32'h80;
        push(0, 0, 1, 32'h55AA);
        tick(); bus.i_req = 0;
        tick(); tick(); tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'h55AA;
        tick(); bus.mem_ready = 0;
        tick();
        // reset during the second BUSY cycle aborts without ack
        bus.i_req = 1; bus.i_addr = 32'h300;
        tick(); bus.i_req = 0;
        tick(); rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_mem_req", 32'(bus.mem_req), 0);
        tick(); bus.mem_ready = 1;
        @(negedge clk);
        chk("abort_ready_busy", 32'(bus.busy), 0);
        tick(); bus.mem_ready = 0;
        tick(); tick();
        chk("queue_drained", q.size(), 0);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
